// File: rtl/normalise_sum_pipe.sv
// Adder normalisation stage with a 2-entry valid/ready output buffer.
// Define NORM_STICKY_EN to fold the carry shift-out bit into the sticky bit.
module normalise_sum_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter logic [EXP_W-1:0] ZERO_EXP = 8'h82
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 idle_in,
    input  logic [EXP_W+MAN_W:0] sout_in,
    input  logic [MAN_W+4:0]     sum_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 idle_out,
    output logic [EXP_W+MAN_W:0] sout_out,
    output logic [MAN_W+4:0]     sum_out,
    output logic                 ovf_out,
    output logic                 unf_out
);
    localparam int SUM_W = MAN_W + 5;
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int LZ_W  = $clog2(MAN_W + 1);
    localparam int CMP_W = ((EXP_W > LZ_W) ? EXP_W : LZ_W) + 1;
    localparam int E_W   = 3 + W + SUM_W;

    logic [EXP_W-1:0] exp_in_s;
    logic [MAN_W:0]   field_s;
    logic [EXP_W:0]   exp_inc_s;
    logic [LZ_W-1:0]  lzc_s;
    logic [CMP_W-1:0] lzc_ext_s;
    logic [CMP_W-1:0] exp_ext_s;
    logic [CMP_W-1:0] exp_sub_s;
    logic [SUM_W-1:0] sum_shr_s;
    logic [EXP_W-1:0] nrm_exp_s;
    logic [SUM_W-1:0] nrm_sum_s;
    logic             nrm_ovf_s;
    logic             nrm_unf_s;
    logic [E_W-1:0]   entry_s;

    assign exp_in_s  = sout_in[W-2:MAN_W];
    assign field_s   = sum_in[SUM_W-2:3];
    assign exp_inc_s = {1'b0, exp_in_s} + {{EXP_W{1'b0}}, 1'b1};
    assign lzc_ext_s = CMP_W'(lzc_s);
    assign exp_ext_s = CMP_W'(exp_in_s);
    assign exp_sub_s = exp_ext_s - lzc_ext_s;

`ifdef NORM_STICKY_EN
    assign sum_shr_s = {1'b0, sum_in[SUM_W-1:2], sum_in[1] | sum_in[0]};
`else
    assign sum_shr_s = {1'b0, sum_in[SUM_W-1:1]};
`endif

    // Leading-zero count over hidden..LSB; the highest set bit wins.
    always_comb begin
        lzc_s = {LZ_W{1'b0}};
        for (int i = 0; i <= MAN_W; i++) begin
            lzc_s = field_s[i] ? LZ_W'(MAN_W - i) : lzc_s;
        end
    end

    // Normalise: priority idle > carry > zero > left shift.
    always_comb begin
        nrm_exp_s = exp_in_s;
        nrm_sum_s = {SUM_W{1'b0}};
        nrm_ovf_s = 1'b0;
        nrm_unf_s = 1'b0;
        if (idle_in) begin
            nrm_exp_s = exp_in_s;
        end else if (sum_in[SUM_W-1]) begin
            nrm_sum_s = sum_shr_s;
            if (exp_inc_s >= {1'b0, {EXP_W{1'b1}}}) begin
                nrm_ovf_s = 1'b1;
                nrm_exp_s = {EXP_W{1'b1}};
            end else begin
                nrm_exp_s = exp_inc_s[EXP_W-1:0];
            end
        end else if (field_s == {(MAN_W+1){1'b0}}) begin
            nrm_exp_s = ZERO_EXP;
        end else begin
            nrm_sum_s = sum_in << lzc_s;
            if (lzc_ext_s > exp_ext_s) begin
                nrm_unf_s = 1'b1;
                nrm_exp_s = {EXP_W{1'b0}};
            end else begin
                nrm_exp_s = exp_sub_s[EXP_W-1:0];
            end
        end
    end

    assign entry_s = {idle_in, nrm_ovf_s, nrm_unf_s, sout_in[W-1], nrm_exp_s,
                      sout_in[MAN_W-1:0], nrm_sum_s};

    logic [E_W-1:0] mem_r [2];
    logic           wr_ptr_r;
    logic           rd_ptr_r;
    logic [1:0]     count_r;
    logic           in_ready_r;
    logic           out_valid_r;
    logic [E_W-1:0] head_r;
    logic           push_s;
    logic           pop_s;
    logic [1:0]     count_nxt_s;
    logic           rd_ptr_nxt_s;
    logic [E_W-1:0] head_nxt_s;

    assign push_s       = in_valid & in_ready_r;
    assign pop_s        = out_valid_r & out_ready;
    assign count_nxt_s  = count_r + {1'b0, push_s} - {1'b0, pop_s};
    assign rd_ptr_nxt_s = rd_ptr_r ^ pop_s;

    // Next head: the beat being written lands at the head when it is the oldest one.
    always_comb begin
        head_nxt_s = {E_W{1'b0}};
        if (count_nxt_s == 2'd0) begin
            head_nxt_s = {E_W{1'b0}};
        end else if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_nxt_s = entry_s;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Buffer storage, pointers, occupancy and registered head/ready.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_r[0]    <= {E_W{1'b0}};
            mem_r[1]    <= {E_W{1'b0}};
            wr_ptr_r    <= 1'b0;
            rd_ptr_r    <= 1'b0;
            count_r     <= 2'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            head_r      <= {E_W{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= entry_s;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            rd_ptr_r    <= rd_ptr_nxt_s;
            count_r     <= count_nxt_s;
            in_ready_r  <= (count_nxt_s < 2'd2);
            out_valid_r <= (count_nxt_s != 2'd0);
            head_r      <= head_nxt_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign idle_out  = head_r[E_W-1];
    assign ovf_out   = head_r[E_W-2];
    assign unf_out   = head_r[E_W-3];
    assign sout_out  = head_r[W+SUM_W-1:SUM_W];
    assign sum_out   = head_r[SUM_W-1:0];

endmodule
